// File: rtl/motor_step_sequencer.sv
// motor_step_sequencer: queues move commands and emits a trapezoidal step_en pulse train for the H-bridge driver
// Ports: clk, PRESERN (sync, active-high reset); cmd_valid/cmd_ready/cmd_dir/cmd_steps push moves;
// drv_load/drv_counter/drv_dir hand each move to the driver; step_en pulses once per step;
// busy is high while loading, running or dwelling; move_done pulses when the dwell ends;
// fifo_count is the number of queued commands. Define MOTOR_STEP_ABORT_EN to add the abort input.
module motor_step_sequencer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int START_PERIOD = 16,
    parameter int MIN_PERIOD   = 4,
    parameter int ACCEL_STEP   = 2,
    parameter int DWELL        = 8,
    parameter int PW           = 16
) (
    input  logic                          clk,
    input  logic                          PRESERN,
`ifdef MOTOR_STEP_ABORT_EN
    input  logic                          abort,
`endif
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_dir,
    input  logic [31:0]                   cmd_steps,
    output logic                          drv_load,
    output logic [31:0]                   drv_counter,
    output logic                          drv_dir,
    output logic                          step_en,
    output logic                          busy,
    output logic                          move_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DWELL_ST} state_t;
    state_t        state;
    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [32:0]   head;
    logic [PW-1:0] p, timer, ramp, p_nx;
    logic [31:0]   remaining, rem_nx;
    logic [PW:0]   p_up, p_dn;
    logic          push, pop, kill, decel, accel;
`ifdef MOTOR_STEP_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif
    // Period update after a step: decelerate once the steps left fit inside the
    // ramp already climbed, otherwise accelerate until the floor; clamps in PW+1 bits.
    always_comb begin
        head      = mem[rd_ptr];
        cmd_ready = fifo_count < (AW+1)'(FIFO_DEPTH);
        push      = cmd_valid && cmd_ready && !kill;
        pop       = state == LOAD && !kill;
        busy      = state != IDLE;
        rem_nx    = remaining - 32'd1;
        p_up      = {1'b0, p} + (PW+1)'(ACCEL_STEP);
        p_dn      = {1'b0, p} - (PW+1)'(ACCEL_STEP);
        decel     = rem_nx <= 32'(ramp);
        accel     = p > PW'(MIN_PERIOD);
        p_nx      = decel ? (p_up > (PW+1)'(START_PERIOD) ? PW'(START_PERIOD) : p_up[PW-1:0])
                  : accel ? ((p_dn[PW] || p_dn < (PW+1)'(MIN_PERIOD)) ? PW'(MIN_PERIOD) : p_dn[PW-1:0])
                  : p;
    end
    always_ff @(posedge clk) begin
        if (PRESERN) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            drv_load    <= 1'b0;
            step_en     <= 1'b0;
            move_done   <= 1'b0;
            drv_counter <= '0;
            drv_dir     <= 1'b1;
            p           <= PW'(START_PERIOD);
            timer       <= '0;
            remaining   <= '0;
            ramp        <= '0;
        end else begin
            drv_load  <= 1'b0;
            step_en   <= 1'b0;
            move_done <= 1'b0;
            if (push) begin
                mem[wr_ptr] <= {cmd_dir, cmd_steps};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            rd_ptr     <= kill ? wr_ptr : rd_ptr + AW'(pop);
            fifo_count <= kill ? '0 : fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            if (kill) begin
                if (state != IDLE) begin
                    drv_load    <= 1'b1;
                    drv_counter <= '0;
                    timer       <= PW'(DWELL - 1);
                    state       <= DWELL_ST;
                end
            end else begin
                case (state)
                    IDLE: if (fifo_count != '0) state <= LOAD;
                    LOAD: begin
                        drv_load    <= 1'b1;
                        drv_dir     <= head[32];
                        drv_counter <= head[31:0];
                        remaining   <= head[31:0];
                        p           <= PW'(START_PERIOD);
                        ramp        <= '0;
                        timer       <= head[31:0] == '0 ? PW'(DWELL - 1) : PW'(START_PERIOD - 1);
                        state       <= head[31:0] == '0 ? DWELL_ST : RUN;
                    end
                    RUN: begin
                        if (timer == '0) begin
                            step_en   <= 1'b1;
                            remaining <= rem_nx;
                            if (rem_nx == '0) begin
                                timer <= PW'(DWELL - 1);
                                state <= DWELL_ST;
                            end else begin
                                p     <= p_nx;
                                timer <= p_nx - PW'(1);
                                ramp  <= decel ? ramp - PW'(1) : accel ? ramp + PW'(1) : ramp;
                            end
                        end else begin
                            timer <= timer - PW'(1);
                        end
                    end
                    DWELL_ST: begin
                        if (timer == '0) begin
                            move_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            timer <= timer - PW'(1);
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_motor_step_sequencer.sv
// tb_motor_step_sequencer: directed moves checked against a schedule-based reference model
module tb_motor_step_sequencer;
    localparam int DEPTH = 4, SP = 16, MP = 4, AS = 2, DW = 8;
    typedef struct packed {logic dir; logic [31:0] steps;} cmd_t;
    typedef int q_t[$];
    logic        clk = 0, PRESERN = 1, cmd_valid = 0, cmd_dir = 0, abort = 0;
    logic [31:0] cmd_steps = 0;
    logic        cmd_ready, drv_load, drv_dir, step_en, busy, move_done;
    logic [31:0] drv_counter;
    logic [2:0]  fifo_count;
    int          n_chk = 0, n_fail = 0, cyc = 0;
    cmd_t        q[$];
    int          st[$];
    int          load_t = -1, done_t = -1;
    bit          m_busy = 0, exp_load = 0, exp_step = 0, exp_done = 0;
    logic [31:0] exp_ctr = 0;
    logic        exp_dir = 1;
    int          load_log[$], step_log[$], done_log[$];
    bit          saw_full;

    always #5 clk = ~clk;

    motor_step_sequencer dut (
        .clk(clk), .PRESERN(PRESERN),
`ifdef MOTOR_STEP_ABORT_EN
        .abort(abort),
`endif
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
        .drv_load(drv_load), .drv_counter(drv_counter), .drv_dir(drv_dir), .step_en(step_en),
        .busy(busy), .move_done(move_done), .fifo_count(fifo_count)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Step intervals of an n-step move: first interval START, then the period
    // shrinks by ACCEL per step to the floor and grows back once the steps left
    // no longer exceed the number of acceleration steps taken.
    function automatic q_t gaps(int n);
        q_t g;
        int p = SP, r = 0;
        if (n > 0) g.push_back(SP);
        for (int i = 1; i < n; i++) begin
            if (n - i <= r) begin
                p = (p + AS > SP) ? SP : p + AS;
                r--;
            end else if (p > MP) begin
                p = (p - AS < MP) ? MP : p - AS;
                r++;
            end
            g.push_back(p);
        end
        return g;
    endfunction

    // Reference: absolute cycle numbers of every load, step and done pulse.
    always @(posedge clk) begin : model
        int cnt0, t;
        bit push_ok, sees;
        q_t g;
        cyc++;
        exp_load = 0;
        exp_step = 0;
        exp_done = 0;
        if (PRESERN) begin
            q.delete();
            st.delete();
            m_busy = 0;
            load_t = -1;
            done_t = -1;
            exp_ctr = 0;
            exp_dir = 1;
        end else begin
            cnt0 = q.size();
            push_ok = cmd_valid && cnt0 < DEPTH && !abort;
            sees = !m_busy && cnt0 > 0 && !abort;
            if (abort) begin
                q.delete();
                if (m_busy) begin
                    exp_load = 1;
                    exp_ctr = 0;
                    st.delete();
                    load_t = -1;
                    done_t = cyc + DW;
                end
            end else begin
                if (cyc == load_t) begin
                    exp_load = 1;
                    exp_dir = q[0].dir;
                    exp_ctr = q[0].steps;
                    void'(q.pop_front());
                end
                if (cyc == done_t) begin
                    exp_done = 1;
                    m_busy = 0;
                end
                if (st.size() > 0 && st[0] == cyc) begin
                    exp_step = 1;
                    void'(st.pop_front());
                end
                if (sees) begin
                    load_t = cyc + 1;
                    t = load_t;
                    g = gaps(int'(q[0].steps));
                    foreach (g[i]) begin
                        t += g[i];
                        st.push_back(t);
                    end
                    done_t = t + DW;
                    m_busy = 1;
                end
                if (push_ok) q.push_back({cmd_dir, cmd_steps});
            end
        end
    end

    always @(negedge clk) begin
        chk("drv_load", drv_load, exp_load);
        chk("step_en", step_en, exp_step);
        chk("move_done", move_done, exp_done);
        chk("busy", busy, m_busy);
        chk("fifo_count", fifo_count, q.size());
        chk("cmd_ready", cmd_ready, q.size() < DEPTH);
        chk("drv_counter", drv_counter, exp_ctr);
        chk("drv_dir", drv_dir, exp_dir);
        if (drv_load) load_log.push_back(cyc);
        if (step_en) step_log.push_back(cyc);
        if (move_done) done_log.push_back(cyc);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(bit d, int s);
        cmd_dir = d;
        cmd_steps = 32'(s);
        cmd_valid = 1;
        tick();
        cmd_valid = 0;
    endtask

    task automatic clear_logs();
        load_log.delete();
        step_log.delete();
        done_log.delete();
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || fifo_count != 0) && k < 2000) begin
            tick();
            k++;
        end
        chk("idle_timeout", k < 2000, 1);
    endtask

    task automatic wait_steps(int n);
        int k = 0;
        while (step_log.size() < n && k < 1000) begin
            tick();
            k++;
        end
        chk("steps_timeout", k < 1000, 1);
    endtask

    task automatic check_gaps(string name, q_t e);
        chk({name, "_nsteps"}, step_log.size(), e.size());
        if (load_log.size() > 0)
            foreach (e[i])
                if (i < step_log.size())
                    chk($sformatf("%s_gap%0d", name, i), step_log[i] - (i == 0 ? load_log[0] : step_log[i-1]), e[i]);
    endtask

    initial begin
        q_t e;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_fifo", fifo_count, 0);
        chk("rst_dir", drv_dir, 1);
        chk("rst_ctr", drv_counter, 0);
        chk("rst_ready", cmd_ready, 1);
        PRESERN = 0;
        tick();

        clear_logs();
        push(1, 3);
        wait_idle();
        chk("t1_loads", load_log.size(), 1);
        chk("t1_ctr", drv_counter, 3);
        chk("t1_dir", drv_dir, 1);
        e = '{16, 14, 16};
        check_gaps("t1", e);
        chk("t1_dones", done_log.size(), 1);
        if (done_log.size() == 1 && step_log.size() == 3) chk("t1_dwell", done_log[0] - step_log[2], 8);

        clear_logs();
        push(0, 20);
        wait_idle();
        chk("t2_dir", drv_dir, 0);
        e = '{16, 14, 12, 10, 8, 6, 4, 4, 4, 4, 4, 4, 4, 4, 6, 8, 10, 12, 14, 16};
        check_gaps("t2", e);

        clear_logs();
        push(1, 0);
        wait_idle();
        chk("t3_loads", load_log.size(), 1);
        chk("t3_ctr", drv_counter, 0);
        chk("t3_steps", step_log.size(), 0);
        if (done_log.size() == 1 && load_log.size() == 1) chk("t3_dwell", done_log[0] - load_log[0], 8);

        clear_logs();
        push(1, 3);
        saw_full = 0;
        for (int i = 0; i < 5; i++) begin
            int k;
            bit acc;
            k = 0;
            cmd_dir = i[0];
            cmd_steps = 32'(1 + i % 2);
            cmd_valid = 1;
            do begin
                acc = cmd_ready;
                if (!acc) saw_full = 1;
                tick();
                k++;
            end while (!acc && k < 500);
        end
        cmd_valid = 0;
        wait_idle();
        chk("t4_full", saw_full, 1);
        chk("t4_loads", load_log.size(), 6);
        chk("t4_steps", step_log.size(), 10);
        chk("t4_dones", done_log.size(), 6);

        clear_logs();
        push(1, 20);
        wait_steps(8);
        PRESERN = 1;
        tick();
        chk("t5_step", step_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_fifo", fifo_count, 0);
        chk("t5_dir", drv_dir, 1);
        chk("t5_ctr", drv_counter, 0);
        PRESERN = 0;
        tick();
        clear_logs();
        push(0, 2);
        wait_idle();
        e = '{16, 14};
        check_gaps("t5", e);

`ifdef MOTOR_STEP_ABORT_EN
        clear_logs();
        push(1, 20);
        push(0, 2);
        push(1, 2);
        wait_steps(5);
        abort = 1;
        tick();
        abort = 0;
        chk("t6_load", drv_load, 1);
        chk("t6_ctr", drv_counter, 0);
        chk("t6_fifo", fifo_count, 0);
        wait_idle();
        repeat (20) tick();
        chk("t6_steps", step_log.size(), 5);
        chk("t6_loads", load_log.size(), 2);
        chk("t6_dones", done_log.size(), 1);
        if (done_log.size() == 1 && load_log.size() == 2) chk("t6_dwell", done_log[0] - load_log[1], 8);
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/motor_step_sequencer.md
Name: motor_step_sequencer

Overview:
- Upstream stage of the H-bridge motor driver.
- Buffers move commands (direction plus step count) in a small FIFO and loads each command into the driver.
- Generates the per-step clock-enable pulse train with a linear accelerate/cruise/decelerate trapezoid, then dwells before the next move.
- Runs on the system clock; the driver consumes `step_en`, `drv_counter`, `drv_dir` and `drv_load`.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- START_PERIOD, 16, clk cycles between steps at start and end of a move (≥2)
- MIN_PERIOD, 4, cruise period floor (1 ≤ MIN_PERIOD ≤ START_PERIOD)
- ACCEL_STEP, 2, period change per step while ramping (≥1)
- DWELL, 8, idle clk cycles after the last step of a move (≥1)
- PW, 16, period/timer register width

Ports:
- clk  in  1  system clock, all logic on rising edge
- PRESERN  in  1  reset, synchronous, active-high (1 = reset)
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_dir  in  1  1 = forward, 0 = reverse
- cmd_steps  in  32  step count, unsigned
- drv_load  out  1  one-cycle pulse, driver latches `drv_counter`/`drv_dir`
- drv_counter  out  32  step count of the current move
- drv_dir  out  1  direction of the current move
- step_en  out  1  one-cycle pulse per step
- busy  out  1  state ≠ IDLE
- move_done  out  1  one-cycle pulse at the end of a move
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held

Behaviour:

Reset (PRESERN = 1 at a clk edge):
- FIFO emptied; state = IDLE.
- All pulse outputs 0; `drv_counter` = 0; `drv_dir` = 1.
- Period register = START_PERIOD; timer = 0; remaining = 0; ramp = 0.
- Reset overrides any move in progress, including mid-ramp.

FIFO:
- Push when `cmd_valid` and `cmd_ready`.
- `cmd_ready` = (`fifo_count` < FIFO_DEPTH).
- Pop only in the LOAD state.
- Push and pop in the same cycle leave the count unchanged.
- No bypass: a command pushed into an empty FIFO is seen by IDLE on the next cycle.
- Pointers wrap modulo FIFO_DEPTH.

State machine:
- IDLE: if `fifo_count` > 0, go to LOAD.
- LOAD (1 cycle):
  - Pop the head entry.
  - `drv_load` = 1; `drv_counter` ← steps; `drv_dir` ← dir.
  - remaining ← steps; p ← START_PERIOD; ramp ← 0; timer ← START_PERIOD − 1.
  - If steps = 0: go to DWELL_ST with no `step_en` pulses. Otherwise go to RUN.
- RUN: timer decrements each cycle. When timer = 0:
  - `step_en` = 1 that cycle; remaining ← remaining − 1.
  - If the new remaining = 0: go to DWELL_ST.
  - Else if new remaining ≤ ramp (decelerate): p ← min(p + ACCEL_STEP, START_PERIOD); ramp ← ramp − 1.
  - Else if p > MIN_PERIOD (accelerate): p ← max(p − ACCEL_STEP, MIN_PERIOD); ramp ← ramp + 1.
  - Else (cruise): p unchanged.
  - timer ← (updated p) − 1.
- Step timing:
  - First `step_en` occurs exactly START_PERIOD cycles after the LOAD cycle.
  - Consecutive `step_en` pulses are separated by the updated p.
- Arithmetic: the min/max on p is computed in PW+1 bits so it cannot overflow or underflow.
- DWELL_ST:
  - Counts DWELL cycles.
  - On the last cycle, `move_done` = 1 and go to IDLE.
  - A FIFO entry is loaded no earlier than the cycle after `move_done`.
- Direction reversal between queued moves needs no special handling; DWELL_ST separates every pair of moves.
- `busy` = 1 in LOAD, RUN and DWELL_ST.

Optional Feature:
- Macro: MOTOR_STEP_ABORT_EN.
- When defined, adds input port `abort` (1 bit). When `abort` = 1 at any cycle:
  - FIFO is flushed (`fifo_count` ← 0).
  - `step_en` is suppressed from that cycle.
  - `drv_counter` ← 0 with a `drv_load` pulse.
  - State goes to DWELL_ST, so `move_done` still fires DWELL cycles later.
  - If abort and a push occur in the same cycle, the abort wins: the pushed entry is discarded.
  - In IDLE, abort flushes the FIFO only; no `drv_load` and no `move_done`.
- When undefined: no `abort` port, and abort logic is not synthesised.

Test Plan:
- Reset, then push {dir = 1, steps = 3} → `drv_load` with counter = 3, dir = 1; `step_en` gaps 16, 14, 16 cycles measured from LOAD; `move_done` 8 cycles after the third step; `busy` drops with it.
- Push steps = 20 → periods 16, 14, …, 4, cruise at 4, then symmetric deceleration back to 16; exactly 20 `step_en` pulses; the last gap is 16.
- Push steps = 0 → `drv_load` with counter = 0; zero `step_en` pulses; `move_done` 8 cycles after LOAD.
- Push 5 commands back-to-back with `cmd_valid` held high → `cmd_ready` low after 4 accepted; the 5th is accepted once LOAD pops; moves execute in order; reversing direction between moves gives each its own `drv_load` and dwell.
- Assert PRESERN mid-RUN of a 20-step move → next cycle: `step_en` = 0, `busy` = 0, `fifo_count` = 0, `drv_dir` = 1, `drv_counter` = 0; a new command afterwards restarts at period 16.
- With MOTOR_STEP_ABORT_EN: abort during step 5 of 20 with 2 commands queued → no further `step_en`; `drv_load` with counter = 0; `fifo_count` = 0; `move_done` 8 cycles later.
